// File: rtl/mul_serial_pkg.sv
// Shared types and sizing helpers for the digit-serial multiplier.
// The reduction wrapper sizes its pipeline alignment from mul_serial_lat().
package mul_serial_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } state_e;

    function automatic int unsigned mul_serial_iter(input int unsigned logq, input int unsigned d);
        return (logq + d - 1) / d;
    endfunction

    // Cycles from accept edge to out_valid.
    function automatic int unsigned mul_serial_lat(input int unsigned logq, input int unsigned d);
        return mul_serial_iter(logq, d);
    endfunction

endpackage

// File: rtl/mul_serial_if.sv
// Operand/result handshake bundle between the operand source, mul_serial and the reduction stage.
interface mul_serial_if #(
    parameter int unsigned LOGQ  = 60,
    parameter int unsigned LOGQH = 43
);
    logic                  in_valid;
    logic                  in_ready;
    logic [LOGQ-1:0]       A;
    logic [LOGQ-1:0]       B;
    logic [LOGQH-1:0]      qH_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*LOGQ-1:0]     C;
    logic [LOGQH-1:0]      qH_out;

    modport master (
        output in_valid, A, B, qH_in, out_ready,
        input  in_ready, out_valid, C, qH_out
    );

    modport slave (
        input  in_valid, A, B, qH_in, out_ready,
        output in_ready, out_valid, C, qH_out
    );
endinterface

// File: rtl/mul_serial_pp_acc.sv
// One multiply step: acc + (A * digit) << (cnt * D). Kept separate so the
// LOGQ x D product maps cleanly onto DSP blocks.
module mul_serial_pp_acc #(
    parameter int unsigned LOGQ = 60,
    parameter int unsigned D    = 17,
    parameter int unsigned CntW = 2
) (
    input  logic [2*LOGQ-1:0] acc_i,
    input  logic [LOGQ-1:0]   a_i,
    input  logic [D-1:0]      digit_i,
    input  logic [CntW-1:0]   cnt_i,
    output logic [2*LOGQ-1:0] acc_o
);
    localparam int unsigned PpW  = LOGQ + D;
    localparam int unsigned AccW = 2 * LOGQ;

    logic [PpW-1:0]  pp;
    logic [AccW-1:0] pp_sh;

    assign pp    = PpW'(a_i) * PpW'(digit_i);
    // Bits shifted past AccW are always zero since A*B < 2^(2*LOGQ).
    assign pp_sh = AccW'(pp) << (32'(cnt_i) * D);
    assign acc_o = acc_i + pp_sh;
endmodule

// File: rtl/mul_serial.sv
// Digit-serial unsigned multiplier C = A*B, one D-bit digit of B per cycle,
// with qH carried alongside each operand pair.
module mul_serial
    import mul_serial_pkg::*;
#(
    parameter int unsigned LOGQ  = 60,
    parameter int unsigned LOGQH = 43,
    parameter int unsigned D     = 17
) (
    input logic         clk,
    input logic         rst,
    mul_serial_if.slave bus
);
    localparam int unsigned Iter  = mul_serial_iter(LOGQ, D);
    localparam int unsigned CntW  = (Iter > 1) ? $clog2(Iter) : 1;
    localparam int unsigned AccW  = 2 * LOGQ;
    localparam int unsigned BExtW = Iter * D;

    state_e            state_q, state_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [LOGQ-1:0]   a_q, a_d;
    logic [LOGQ-1:0]   b_q, b_d;
    logic [LOGQH-1:0]  qh_q, qh_d;

    logic              in_ready;
    logic              accept;
    logic              last_digit;
    logic [BExtW-1:0]  b_ext;
    logic [D-1:0]      digit;
    logic [AccW-1:0]   acc_next;

    // Zero-extending B makes the short last digit fall out naturally.
    assign b_ext      = BExtW'(b_q);
    assign digit      = D'(b_ext >> (32'(cnt_q) * D));
    assign last_digit = (cnt_q == CntW'(Iter - 1));

    mul_serial_pp_acc #(
        .LOGQ (LOGQ),
        .D    (D),
        .CntW (CntW)
    ) u_pp_acc (
        .acc_i   (acc_q),
        .a_i     (a_q),
        .digit_i (digit),
        .cnt_i   (cnt_q),
        .acc_o   (acc_next)
    );

    // Only combinational path through the block: out_ready -> in_ready.
    assign in_ready = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        qh_d    = qh_q;

        case (state_q)
            StIdle: begin
                if (accept) state_d = StMul;
            end
            StMul: begin
                acc_d = acc_next;
                if (last_digit) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = accept ? StMul : StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            a_d   = bus.A;
            b_d   = bus.B;
            qh_d  = bus.qH_in;
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            qh_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            qh_q    <= qh_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == StDone);
    assign bus.C         = acc_q;
    assign bus.qH_out    = qh_q;
endmodule
